aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. Accepts a 128-bit block over a valid/ready handshake and fetches round keys 0..10 from the key-schedule storage. Drives the shared combinational round datapath (SubBytes/ShiftRows/MixColumns followed by the AddRoundKey XOR) once per round and holds the running state between rounds. Returns the ciphertext over a second valid/ready handshake. Sits between the UART framing logic and the round datapath; one block in flight at a time.

---
 rtl/aes_round_sequencer.sv | 114 +++++++++++
 tb/tb_aes_round_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: accepts one block, steps the shared round datapath
// through rounds 0..NR with keys fetched from storage, then hands back the ciphertext.
module aes_round_sequencer #(
    parameter int NR   = 10,
    parameter int KA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_loaded,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    output logic [KA_W-1:0] key_addr,
    input  logic [127:0]    key_data,
    output logic [127:0]    rf_state,
    output logic [127:0]    rf_key,
    output logic [1:0]      rf_mode,
    input  logic [127:0]    rf_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ROUND,
        DONE
    } state_t;

    localparam logic [KA_W-1:0] LAST_ROUND = KA_W'(NR);
    localparam logic [KA_W:0]   LAST_WIDE  = (KA_W+1)'(NR);

    state_t          fsm_q, fsm_d;
    logic [127:0]    stateReg_q, stateReg_d;
    logic [KA_W-1:0] round_q, round_d;
    logic [KA_W-1:0] keyAddr_q, keyAddr_d;
    logic [KA_W:0]   roundPlus2;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            stateReg_q <= '0;
            round_q    <= '0;
            keyAddr_q  <= '0;
        end else begin
            fsm_q      <= fsm_d;
            stateReg_q <= stateReg_d;
            round_q    <= round_d;
            keyAddr_q  <= keyAddr_d;
        end
    end

    // Key reads are issued two rounds ahead to cover the one-cycle storage latency,
    // clamped at the last key so the address never leaves the valid range.
    assign roundPlus2 = {1'b0, round_q} + (KA_W+1)'(2);

    always_comb begin
        fsm_d      = fsm_q;
        stateReg_d = stateReg_q;
        round_d    = round_q;
        keyAddr_d  = keyAddr_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        rf_mode    = 2'd0;
        case (fsm_q)
            IDLE: begin
                in_ready = key_loaded;
                if (in_valid && key_loaded) begin
                    stateReg_d = in_data;
                    keyAddr_d  = '0;
                    round_d    = '0;
                    fsm_d      = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                keyAddr_d = KA_W'(1);
                fsm_d     = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (round_q == '0) begin
                    rf_mode = 2'd0;
                end else if (round_q == LAST_ROUND) begin
                    rf_mode = 2'd2;
                end else begin
                    rf_mode = 2'd1;
                end
                stateReg_d = rf_result;
                keyAddr_d  = (roundPlus2 > LAST_WIDE) ? LAST_ROUND : roundPlus2[KA_W-1:0];
                round_d    = round_q + KA_W'(1);
                if (round_q == LAST_ROUND) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign key_addr = keyAddr_q;
    assign rf_state = stateReg_q;
    assign rf_key   = key_data;
    assign out_data = stateReg_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a behavioural AES round function and an expanded-key
// RAM surround the sequencer, and known FIPS-197 / SP800-38A ciphertexts are checked.
module tb_aes_round_sequencer;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT0 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_loaded;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic [127:0] rf_state;
    logic [127:0] rf_key;
    logic [1:0]   rf_mode;
    logic [127:0] rf_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int vecCount  = 0;
    int missCount = 0;

    logic [7:0]   sbox   [256];
    logic [127:0] keyRam [16];

    aes_round_sequencer #(.NR(10), .KA_W(4)) dut (
        .clk(clk), .rst(rst), .key_loaded(key_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_addr(key_addr), .key_data(key_data),
        .rf_state(rf_state), .rf_key(rf_key), .rf_mode(rf_mode), .rf_result(rf_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) key_data <= keyRam[key_addr];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Column-major byte order: byte 4*c+r sits at bits [127-8*(4*c+r) -: 8].
    function automatic logic [127:0] roundModel(input logic [127:0] st, input logic [127:0] k,
                                                input logic [1:0] mode);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        if (mode == 2'd0) return st ^ k;
        for (int i = 0; i < 16; i++) b[i] = sbox[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
        if (mode == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                b[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                b[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                b[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                b[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end else begin
            for (int i = 0; i < 16; i++) b[i] = t[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    assign rf_result = roundModel(rf_state, rf_key, rf_mode);

    task automatic buildTables();
        logic [7:0]  inv, base, s, x, rcon;
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 256; i++) begin
            inv  = 8'h01;
            base = 8'(i);
            for (int e = 0; e < 8; e++) begin
                if (e != 0) inv = gmul(inv, base);
                base = gmul(base, base);
            end
            s = inv;
            x = inv;
            for (int k = 0; k < 4; k++) begin
                x = {x[6:0], x[7]};
                s = s ^ x;
            end
            sbox[i] = s ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp = tmp ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            keyRam[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_loaded = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        vecCount++; if (key_addr !== 4'd0) begin missCount++; $display("[TB] FAIL reset_key_addr got %0d want 0", key_addr); end
        vecCount++; if (rf_mode !== 2'd0) begin missCount++; $display("[TB] FAIL reset_rf_mode got %0d want 0", rf_mode); end
        vecCount++; if (out_data !== 128'h0) begin missCount++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
        vecCount++; if (in_ready !== 1'b0) begin missCount++; $display("[TB] FAIL reset_in_ready_unloaded got %b want 0", in_ready); end
        key_loaded = 1'b1;
        #1;
        vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL reset_in_ready_loaded got %b want 1", in_ready); end
    endtask

    task automatic test_fips_vector();
        logic [3:0] expAddr;
        logic [1:0] expMode;
        @(negedge clk);
        in_data = PT0; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL fips_accept got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            expAddr = (cyc == 12) ? 4'd10 : 4'(cyc - 1);
            vecCount++;
            if (key_addr !== expAddr) begin missCount++; $display("[TB] FAIL seq_key_addr cyc %0d got %0d want %0d", cyc, key_addr, expAddr); end
            if (cyc >= 2) begin
                expMode = (cyc == 2) ? 2'd0 : ((cyc == 12) ? 2'd2 : 2'd1);
                vecCount++;
                if (rf_mode !== expMode) begin missCount++; $display("[TB] FAIL seq_rf_mode cyc %0d got %0d want %0d", cyc, rf_mode, expMode); end
            end
            vecCount++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin missCount++; $display("[TB] FAIL seq_busy cyc %0d got valid %b busy %b want 0/1", cyc, out_valid, busy); end
            @(negedge clk);
        end
        vecCount++; if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL fips_latency out_valid got %b want 1 at cycle 13", out_valid); end
        vecCount++; if (out_data !== CT0) begin missCount++; $display("[TB] FAIL fips_ct got %h want %h", out_data, CT0); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL fips_done_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in_data  = PT1;
        for (int i = 0; i < 20; i++) begin
            vecCount++;
            if (out_valid !== 1'b1 || out_data !== CT0 || in_ready !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL backpressure cyc %0d got valid %b ready %b data %h want 1/0/%h", i, out_valid, in_ready, out_data, CT0);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL bp_release_in_ready got %b want 1", in_ready); end
        vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL bp_release_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_gating();
        int n;
        key_loaded = 1'b0; in_valid = 1'b1; in_data = PT1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecCount++; if (in_ready !== 1'b0) begin missCount++; $display("[TB] FAIL gate_in_ready cyc %0d got %b want 0", i, in_ready); end
            @(negedge clk);
            vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL gate_busy cyc %0d got %b want 0", i, busy); end
        end
        key_loaded = 1'b1;
        #1;
        vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL gate_raise_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; key_loaded = 1'b0;
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL gate_accepted_busy got %b want 1", busy); end
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        key_loaded = 1'b1;
        vecCount++; if (n !== 13) begin missCount++; $display("[TB] FAIL gate_latency got %0d want 13", n); end
        vecCount++; if (out_data !== CT1) begin missCount++; $display("[TB] FAIL gate_ct got %h want %h", out_data, CT1); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        in_data = PT0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        vecCount++; if (key_addr !== 4'd7 || rf_mode !== 2'd1) begin missCount++; $display("[TB] FAIL mid_round6 got addr %0d mode %0d want 7/1", key_addr, rf_mode); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
        vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL mid_out_valid got %b want 0", out_valid); end
        vecCount++; if (out_data !== 128'h0) begin missCount++; $display("[TB] FAIL mid_state got %h want 0", out_data); end
        vecCount++; if (key_addr !== 4'd0 || rf_mode !== 2'd0) begin missCount++; $display("[TB] FAIL mid_addr_mode got %0d/%0d want 0/0", key_addr, rf_mode); end
        #1;
        vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL mid_in_ready got %b want 1", in_ready); end
        in_data = PT2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        vecCount++; if (n !== 13) begin missCount++; $display("[TB] FAIL mid_recover_latency got %0d want 13", n); end
        vecCount++; if (out_data !== CT2) begin missCount++; $display("[TB] FAIL mid_recover_ct got %h want %h", out_data, CT2); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] ptTab [3];
        logic [127:0] ctTab [3];
        int outCyc [3];
        int accIdx, outIdx, cyc;
        ptTab[0] = PT0; ptTab[1] = PT1; ptTab[2] = PT2;
        ctTab[0] = CT0; ctTab[1] = CT1; ctTab[2] = CT2;
        accIdx = 0; outIdx = 0; cyc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (outIdx < 3 && cyc < 80) begin
            if (accIdx >= 3) begin
                in_valid = 1'b0;
            end else begin
                in_data = ptTab[accIdx];
                #1;
                if (in_valid && in_ready) accIdx++;
            end
            if (out_valid === 1'b1) begin
                vecCount++;
                if (out_data !== ctTab[outIdx]) begin missCount++; $display("[TB] FAIL b2b_ct %0d got %h want %h", outIdx, out_data, ctTab[outIdx]); end
                outCyc[outIdx] = cyc;
                outIdx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        vecCount++;
        if (outIdx !== 3) begin
            missCount++;
            $display("[TB] FAIL b2b_count got %0d want 3", outIdx);
        end else begin
            vecCount++; if (outCyc[0] !== 13) begin missCount++; $display("[TB] FAIL b2b_first got cycle %0d want 13", outCyc[0]); end
            vecCount++; if (outCyc[1] - outCyc[0] !== 14) begin missCount++; $display("[TB] FAIL b2b_gap1 got %0d want 14", outCyc[1] - outCyc[0]); end
            vecCount++; if (outCyc[2] - outCyc[1] !== 14) begin missCount++; $display("[TB] FAIL b2b_gap2 got %0d want 14", outCyc[2] - outCyc[1]); end
        end
    endtask

    initial begin
        buildTables();
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_gating();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
